fpga_spi_confreg_bank: RTL and testbench
========================================

// Module: fpga_spi_confreg_bank
// PURPOSE
// - Parametrised ARM->FPGA configuration receiver. Replaces the single-register, spck/ncs-clocked SPI config latch.
// - Oversamples spck/mosi/ncs in the pck0 domain and decodes WORD_W-bit frames as {cmd, pad, data}.
// - Writes one of NUM_REGS configuration registers per frame. Flags malformed frames.
// - Gives each register a one-cycle update strobe, so mode muxes switch glitch-free on pck0.
// PARAMETERS
// WORD_W      16     frame length in bits, MSB first
// CMD_W       4      command field width, taken from frame bits [WORD_W-1 -: CMD_W]
// DATA_W      8      register width, taken from frame bits [DATA_W-1:0]
// NUM_REGS    4      number of configuration registers
// CMD_BASE    1      command code that writes register 0; register i uses CMD_BASE+i
// RST_VAL0    8'hE0  reset value of register 0 (major mode 111, everything off); other registers reset to 0
// SYNC_STAGES 2      synchroniser depth for spck/mosi/ncs, minimum 2
// PORTS
// pck0       in   1                  system clock; must be at least 4x spck
// reset      in   1                  asynchronous, active-high
// spck       in   1                  SPI clock from ARM, asynchronous to pck0
// mosi       in   1                  SPI data, sampled on rising spck
// ncs        in   1                  SPI chip select, active-low; rising edge ends a frame
// conf_flat  out  NUM_REGS*DATA_W    register i at [i*DATA_W +: DATA_W]
// conf_upd   out  NUM_REGS           one-cycle pulse when register i is written
// frame_err  out  1                  sticky: a frame with bit count != WORD_W was received
// err_cnt    out  8                  count of bad frames, saturates at 255
// busy       out  1                  high while a frame is in progress (state SHIFT)
// BEHAVIOUR
// - Reset values: reg0=RST_VAL0, other registers 0; conf_upd=0, frame_err=0, err_cnt=0, busy=0; state WAIT_HI.
// - Inputs: spck, mosi and ncs each pass SYNC_STAGES flops, then an edge detector.
// - Event definitions: spck_rise = synced spck 0->1; ncs_fall and ncs_rise likewise on synced ncs.
// - State machine:
//   - WAIT_HI: leaves when synced ncs=1, goes to IDLE. Guards against reset release in mid-frame.
//   - IDLE: on ncs_fall, clear shift register and bit count, go to SHIFT.
//   - SHIFT: on spck_rise, shift_reg <= {shift_reg[WORD_W-2:0], mosi_s}.
//     - bit_cnt increments and saturates at WORD_W+1.
//     - On ncs_rise, go to COMMIT. ncs_rise has priority over a same-cycle spck_rise; that spck edge is dropped.
//   - COMMIT (exactly one cycle), then IDLE:
//     - If bit_cnt != WORD_W: no register write; frame_err<=1; err_cnt<=err_cnt+1 (saturating).
//     - Else if cmd in [CMD_BASE, CMD_BASE+NUM_REGS-1]: reg[cmd-CMD_BASE] <= data. conf_upd[idx]=1 in the following cycle only.
//     - Else if cmd == CMD_CLR_ERR and data == 8'hA5: clear frame_err and err_cnt.
//     - Otherwise: frame silently ignored, no error.
// - Latency: conf_flat and conf_upd change SYNC_STAGES+2 pck0 cycles after ncs rises at the pin.
// - Register outputs only change in the cycle after COMMIT; conf_flat is glitch-free.
// - busy = (state == SHIFT), registered.
// - Unused padding bits between cmd and data are ignored.
// - Reset in mid-frame: the partial frame is discarded, all registers return to reset values, state goes to WAIT_HI.
// STRUCTURE
// - Package fpga_hf_pkg holds:
//   - CMD_SET_CONFREG = 4'b0001 (equals CMD_BASE)
//   - CMD_CLR_ERR = 4'b1111
//   - CLR_ERR_KEY = 8'hA5
//   - major-mode codes: 000 tx, 001 rx_xcorr, 010 simulate, 011 iso14443a, 100 sniffer, 111 off
//   - state enum {WAIT_HI, IDLE, SHIFT, COMMIT}
// - Sub-module sync_edge: SYNC_STAGES-flop synchroniser plus rise/fall detect. Instantiated for spck and ncs.
// - mosi uses the same synchroniser depth so it stays aligned with spck.
// TESTING
// - After reset, check conf_flat: reg0=8'hE0, others 0, err_cnt=0.
//   - Send 16'h1045 -> reg0=8'h45.
//   - conf_upd=4'b0001 for exactly one cycle, SYNC_STAGES+2 cycles after ncs rises.
// - Send 16'h3012 -> reg2=8'h12 and conf_upd[2] pulses. Then send 16'h70FF (out of range) -> no change, frame_err stays 0.
// - Send a 15-bit frame, then a 17-bit frame.
//   - frame_err=1, err_cnt=2, all registers unchanged.
//   - Then send 16'hF0A5 -> frame_err=0, err_cnt=0.
// - Send 300 bad frames -> err_cnt saturates at 255.
// - spck rises in the same synced cycle as ncs rises on bit 17 -> that bit is dropped and the 16-bit frame commits.
// - Hold ncs low and release reset -> no write until ncs goes high and a full frame arrives.
//   - Assert reset in mid-frame -> registers return to reset values and busy=0.

Source files
------------

// File: rtl/fpga_hf_pkg.sv
// Shared constants for the ARM->FPGA configuration receiver: command codes,
// the error-clear key, major-mode encodings and the frame decoder states.
package fpga_hf_pkg;

  localparam logic [3:0] CMD_SET_CONFREG = 4'b0001;
  localparam logic [3:0] CMD_CLR_ERR     = 4'b1111;
  localparam logic [7:0] CLR_ERR_KEY     = 8'hA5;

  localparam logic [2:0] MODE_TX        = 3'b000;
  localparam logic [2:0] MODE_RX_XCORR  = 3'b001;
  localparam logic [2:0] MODE_SIMULATE  = 3'b010;
  localparam logic [2:0] MODE_ISO14443A = 3'b011;
  localparam logic [2:0] MODE_SNIFFER   = 3'b100;
  localparam logic [2:0] MODE_OFF       = 3'b111;

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    IDLE    = 2'd1,
    SHIFT   = 2'd2,
    COMMIT  = 2'd3
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with single-cycle
// rise/fall pulses derived from the synchronised value.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Resetting to 0 means a line that is already high after reset shows up
  // as a rise, never as a spurious fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/fpga_spi_confreg_bank.sv
// Oversampled SPI frame receiver in the pck0 domain writing a bank of
// configuration registers, with per-register update strobes and error tracking.
module fpga_spi_confreg_bank
  import fpga_hf_pkg::*;
#(
  parameter int                WORD_W      = 16,
  parameter int                CMD_W       = 4,
  parameter int                DATA_W      = 8,
  parameter int                NUM_REGS    = 4,
  parameter int                CMD_BASE    = 1,
  parameter logic [DATA_W-1:0] RST_VAL0    = DATA_W'({MODE_OFF, 5'b00000}),
  parameter int                SYNC_STAGES = 2
) (
  input  logic                       pck0,
  input  logic                       reset,
  input  logic                       spck,
  input  logic                       mosi,
  input  logic                       ncs,
  output logic [NUM_REGS*DATA_W-1:0] conf_flat,
  output logic [NUM_REGS-1:0]        conf_upd,
  output logic                       frame_err,
  output logic [7:0]                 err_cnt,
  output logic                       busy
);

  localparam int               CNT_W   = $clog2(WORD_W + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_OK  = CNT_W'(WORD_W);
  localparam logic [CMD_W-1:0] CMD_LO  = CMD_W'(CMD_BASE);
  localparam logic [CMD_W-1:0] CMD_HI  = CMD_W'(CMD_BASE + NUM_REGS - 1);

  logic spck_rise, spck_s_unused, spck_fall_unused;
  logic ncs_s, ncs_rise, ncs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  state_t state, state_nxt;
  logic [WORD_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [CMD_W-1:0]  frame_cmd, reg_idx;
  logic [DATA_W-1:0] frame_data;
  logic              reg_hit, clr_hit;

  sync_edge #(.STAGES(SYNC_STAGES)) u_spck_sync (
    .clk   (pck0),
    .reset (reset),
    .din   (spck),
    .dout  (spck_s_unused),
    .rise  (spck_rise),
    .fall  (spck_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_ncs_sync (
    .clk   (pck0),
    .reset (reset),
    .din   (ncs),
    .dout  (ncs_s),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  // mosi gets the same depth as spck so the sampled bit lines up with its edge.
  always_ff @(posedge pck0 or posedge reset) begin
    if (reset) mosi_q <= '0;
    else       mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  assign frame_cmd  = shift_reg[WORD_W-1 -: CMD_W];
  assign frame_data = shift_reg[DATA_W-1:0];
  assign reg_hit    = (frame_cmd >= CMD_LO) && (frame_cmd <= CMD_HI);
  assign reg_idx    = frame_cmd - CMD_LO;
  assign clr_hit    = (frame_cmd == CMD_W'(CMD_CLR_ERR)) &&
                      (frame_data == DATA_W'(CLR_ERR_KEY));

  generate
    if (WORD_W - CMD_W > DATA_W) begin : g_pad
      logic pad_unused;
      assign pad_unused = ^shift_reg[WORD_W-CMD_W-1:DATA_W];
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_HI: if (ncs_s)    state_nxt = IDLE;
      IDLE:    if (ncs_fall) state_nxt = SHIFT;
      SHIFT:   if (ncs_rise) state_nxt = COMMIT;
      COMMIT:                state_nxt = IDLE;
      default:               state_nxt = WAIT_HI;
    endcase
  end

  // A spck edge landing in the same cycle as ncs_rise is dropped, so an
  // over-clocked master still commits its first WORD_W bits.
  always_ff @(posedge pck0 or posedge reset) begin
    if (reset) begin
      state     <= WAIT_HI;
      busy      <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      conf_upd  <= '0;
      frame_err <= 1'b0;
      err_cnt   <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= (i == 0) ? RST_VAL0 : '0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt == SHIFT);
      conf_upd <= '0;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
          end
        end
        SHIFT: begin
          if (spck_rise && !ncs_rise) begin
            shift_reg <= {shift_reg[WORD_W-2:0], mosi_s};
            if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        COMMIT: begin
          if (bit_cnt != CNT_OK) begin
            frame_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end else if (reg_hit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (reg_idx == CMD_W'(i)) begin
                regs[i]     <= frame_data;
                conf_upd[i] <= 1'b1;
              end
            end
          end else if (clr_hit) begin
            frame_err <= 1'b0;
            err_cnt   <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign conf_flat[g*DATA_W +: DATA_W] = regs[g];
    end
  endgenerate

endmodule

// File: tb/tb_fpga_spi_confreg_bank.sv
// Directed self-checking bench for fpga_spi_confreg_bank: register writes,
// strobe latency, error frames, saturation, ncs/spck tie and reset mid-frame.
module tb_fpga_spi_confreg_bank;

  logic        pck0 = 1'b0;
  logic        reset, spck, mosi, ncs;
  logic [31:0] conf_flat;
  logic [3:0]  conf_upd;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [3:0] upd_seen;
  int         upd_cycles;

  fpga_spi_confreg_bank dut (
    .pck0      (pck0),
    .reset     (reset),
    .spck      (spck),
    .mosi      (mosi),
    .ncs       (ncs),
    .conf_flat (conf_flat),
    .conf_upd  (conf_upd),
    .frame_err (frame_err),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  always #5 pck0 = ~pck0;

  // Drop ncs and clock out n bits MSB first; ncs is left low.
  task automatic send_bits(input logic [31:0] bits, input int n);
    ncs = 1'b0;
    repeat (4) @(negedge pck0);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      repeat (2) @(negedge pck0);
      spck = 1'b1;
      repeat (3) @(negedge pck0);
      spck = 1'b0;
      repeat (2) @(negedge pck0);
    end
  endtask

  task automatic raise_ncs();
    upd_seen   = 4'b0000;
    upd_cycles = 0;
    @(posedge pck0);
    #1 ncs = 1'b1;
    repeat (8) begin
      @(negedge pck0);
      upd_seen = upd_seen | conf_upd;
      if (conf_upd != 4'b0000) upd_cycles++;
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n);
    send_bits(bits, n);
    raise_ncs();
  endtask

  task automatic test_reset();
    checks++;
    if (conf_flat !== 32'h000000E0) begin
      failures++; $display("[TB] FAIL reset_conf got=%h exp=%h", conf_flat, 32'h000000E0);
    end
    checks++;
    if (err_cnt !== 8'd0 || frame_err !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_err got=%0d/%b exp=0/0", err_cnt, frame_err);
    end
    checks++;
    if (busy !== 1'b0 || conf_upd !== 4'b0000) begin
      failures++; $display("[TB] FAIL reset_busy_upd got=%b/%b exp=0/0000", busy, conf_upd);
    end
  endtask

  task automatic test_write_latency();
    logic [3:0]  upd_hist  [7];
    logic [31:0] flat_hist [7];
    send_bits(32'h1045, 16);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("[TB] FAIL busy_in_frame got=%b exp=1", busy);
    end
    @(posedge pck0);
    #1 ncs = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge pck0);
      upd_hist[k]  = conf_upd;
      flat_hist[k] = conf_flat;
    end
    checks++;
    if (upd_hist[3] !== 4'b0000 || flat_hist[3] !== 32'h000000E0) begin
      failures++; $display("[TB] FAIL early_update got=%b/%h exp=0000/000000e0", upd_hist[3], flat_hist[3]);
    end
    checks++;
    if (upd_hist[4] !== 4'b0001 || flat_hist[4] !== 32'h00000045) begin
      failures++; $display("[TB] FAIL write_reg0 got=%b/%h exp=0001/00000045", upd_hist[4], flat_hist[4]);
    end
    checks++;
    if (upd_hist[5] !== 4'b0000) begin
      failures++; $display("[TB] FAIL upd_one_cycle got=%b exp=0000", upd_hist[5]);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("[TB] FAIL busy_after got=%b exp=0", busy);
    end
  endtask

  task automatic test_reg2_and_out_of_range();
    send_frame(32'h3012, 16);
    checks++;
    if (conf_flat !== 32'h00120045 || upd_seen !== 4'b0100 || upd_cycles != 1) begin
      failures++; $display("[TB] FAIL write_reg2 got=%h/%b/%0d exp=00120045/0100/1", conf_flat, upd_seen, upd_cycles);
    end
    send_frame(32'h70FF, 16);
    checks++;
    if (conf_flat !== 32'h00120045 || upd_seen !== 4'b0000 || frame_err !== 1'b0) begin
      failures++; $display("[TB] FAIL out_of_range got=%h/%b/%b exp=00120045/0000/0", conf_flat, upd_seen, frame_err);
    end
  endtask

  task automatic test_bad_frames();
    send_frame(32'h1234, 15);
    send_frame(32'h1ABCD, 17);
    checks++;
    if (frame_err !== 1'b1 || err_cnt !== 8'd2) begin
      failures++; $display("[TB] FAIL bad_len_err got=%b/%0d exp=1/2", frame_err, err_cnt);
    end
    checks++;
    if (conf_flat !== 32'h00120045 || upd_seen !== 4'b0000) begin
      failures++; $display("[TB] FAIL bad_len_regs got=%h/%b exp=00120045/0000", conf_flat, upd_seen);
    end
    send_frame(32'hF0A5, 16);
    checks++;
    if (frame_err !== 1'b0 || err_cnt !== 8'd0) begin
      failures++; $display("[TB] FAIL clr_err got=%b/%0d exp=0/0", frame_err, err_cnt);
    end
  endtask

  task automatic test_saturation();
    for (int f = 0; f < 255; f++) send_frame(32'h1, 1);
    checks++;
    if (err_cnt !== 8'd255) begin
      failures++; $display("[TB] FAIL err_cnt_255 got=%0d exp=255", err_cnt);
    end
    for (int f = 0; f < 45; f++) send_frame(32'h0, 1);
    checks++;
    if (err_cnt !== 8'd255 || frame_err !== 1'b1) begin
      failures++; $display("[TB] FAIL err_cnt_sat got=%0d/%b exp=255/1", err_cnt, frame_err);
    end
    send_frame(32'hF0A5, 16);
    checks++;
    if (err_cnt !== 8'd0 || frame_err !== 1'b0) begin
      failures++; $display("[TB] FAIL clr_after_sat got=%0d/%b exp=0/0", err_cnt, frame_err);
    end
  endtask

  task automatic test_ncs_spck_tie();
    send_bits(32'h2033, 16);
    mosi = 1'b1;
    repeat (2) @(negedge pck0);
    upd_seen = 4'b0000;
    @(posedge pck0);
    #1;
    spck = 1'b1;
    ncs  = 1'b1;
    repeat (8) begin
      @(negedge pck0);
      upd_seen = upd_seen | conf_upd;
    end
    spck = 1'b0;
    repeat (4) @(negedge pck0);
    checks++;
    if (conf_flat !== 32'h00123345 || upd_seen !== 4'b0010 || frame_err !== 1'b0) begin
      failures++; $display("[TB] FAIL tie_drop got=%h/%b/%b exp=00123345/0010/0", conf_flat, upd_seen, frame_err);
    end
  endtask

  task automatic test_reset_midframe();
    send_bits(32'h40, 8);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("[TB] FAIL busy_midframe got=%b exp=1", busy);
    end
    @(negedge pck0);
    reset = 1'b1;
    #1;
    checks++;
    if (conf_flat !== 32'h000000E0 || busy !== 1'b0 || err_cnt !== 8'd0) begin
      failures++; $display("[TB] FAIL reset_midframe got=%h/%b/%0d exp=000000e0/0/0", conf_flat, busy, err_cnt);
    end
    repeat (3) @(negedge pck0);
    reset = 1'b0;
    send_bits(32'h4077, 16);
    raise_ncs();
    checks++;
    if (conf_flat !== 32'h000000E0 || upd_seen !== 4'b0000 || frame_err !== 1'b0) begin
      failures++; $display("[TB] FAIL wait_hi_guard got=%h/%b/%b exp=000000e0/0000/0", conf_flat, upd_seen, frame_err);
    end
    send_frame(32'h4077, 16);
    checks++;
    if (conf_flat !== 32'h770000E0 || upd_seen !== 4'b1000) begin
      failures++; $display("[TB] FAIL write_reg3 got=%h/%b exp=770000e0/1000", conf_flat, upd_seen);
    end
  endtask

  initial begin
    reset = 1'b1;
    spck  = 1'b0;
    mosi  = 1'b0;
    ncs   = 1'b1;
    repeat (3) @(negedge pck0);
    reset = 1'b0;
    repeat (6) @(negedge pck0);
    test_reset();
    test_write_latency();
    test_reg2_and_out_of_range();
    test_bad_frames();
    test_saturation();
    test_ncs_spck_tie();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
